alu_ex_stage: RTL and testbench



---
 rtl/alu_ex_if.sv | 23 ++
 rtl/alu_ex_stage.sv | 143 ++++++++++++++
 tb/tb_alu_ex_stage.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/alu_ex_if.sv
// Decode-to-execute operand bus and execute-to-writeback result bus.
// The master side is the decode stage; the slave side is the execute unit.
interface alu_ex_if #(
    parameter int WIDTH = 16
);
    logic                    in_valid;
    logic [3:0]              opcode;
    logic signed [WIDTH-1:0] A;
    logic signed [WIDTH-1:0] B;
    logic                    out_valid;
    logic [WIDTH-1:0]        Result;
    logic [2:0]              Flags;

    modport master (
        output in_valid, opcode, A, B,
        input  out_valid, Result, Flags
    );

    modport slave (
        input  in_valid, opcode, A, B,
        output out_valid, Result, Flags
    );
endinterface

// File: rtl/alu_ex_stage.sv
// Two-stage execute unit: saturating ADD/SUB, XOR and four-lane saturating PADDSB,
// with a registered result and Z/V/N flag register, under stall/flush control.
module alu_ex_stage #(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         flush,
    alu_ex_if.slave      bus
);

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_PADDSB = 4'b0111;

    // Returns {overflow, saturated sum}; overflow is judged on the operands as given,
    // so SUB passes ~B with cin=1 and B=0x8000 saturates correctly.
    function automatic logic [WIDTH:0] sat_add(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b,
        input logic                    cin
    );
        logic [WIDTH-1:0] s;
        logic             pos_ovf;
        logic             neg_ovf;
        s       = a + b + {{(WIDTH-1){1'b0}}, cin};
        pos_ovf = ~a[WIDTH-1] & ~b[WIDTH-1] &  s[WIDTH-1];
        neg_ovf =  a[WIDTH-1] &  b[WIDTH-1] & ~s[WIDTH-1];
        if (pos_ovf)
            return {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
        else if (neg_ovf)
            return {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
        else
            return {1'b0, s};
    endfunction

    function automatic logic [3:0] sat_lane(
        input logic signed [3:0] a,
        input logic signed [3:0] b
    );
        logic signed [4:0] s;
        s = {a[3], a} + {b[3], b};
        if (s > 5'sd7)
            return 4'b0111;
        else if (s < -5'sd8)
            return 4'b1000;
        else
            return s[3:0];
    endfunction

    function automatic logic [WIDTH-1:0] paddsb(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH / 4; i++)
            r[4*i +: 4] = sat_lane(a[4*i +: 4], b[4*i +: 4]);
        return r;
    endfunction

    logic                    vld_p1;
    logic [3:0]              op_p1;
    logic signed [WIDTH-1:0] a_p1;
    logic signed [WIDTH-1:0] b_p1;

    logic                    vld_p2;
    logic [WIDTH-1:0]        res_p2;
    logic [2:0]              flags_p2;

    logic [WIDTH:0]          add_c;
    logic [WIDTH:0]          sub_c;
    logic [WIDTH-1:0]        res_c;
    logic [2:0]              flags_c;

    // Stage 1 -> stage 2: execute on the captured operands
    always_comb begin
        add_c   = sat_add(a_p1, b_p1, 1'b0);
        sub_c   = sat_add(a_p1, ~b_p1, 1'b1);
        res_c   = '0;
        flags_c = flags_p2;
        case (op_p1)
            OP_ADD: begin
                res_c   = add_c[WIDTH-1:0];
                flags_c = {(res_c == '0), add_c[WIDTH], res_c[WIDTH-1]};
            end
            OP_SUB: begin
                res_c   = sub_c[WIDTH-1:0];
                flags_c = {(res_c == '0), sub_c[WIDTH], res_c[WIDTH-1]};
            end
            OP_XOR: begin
                res_c      = a_p1 ^ b_p1;
                flags_c[2] = (res_c == '0);
            end
            OP_PADDSB: begin
                res_c = paddsb(a_p1, b_p1);
            end
            default: begin
                res_c = '0;
            end
        endcase
    end

    // Stage 1: operand capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            op_p1  <= '0;
            a_p1   <= '0;
            b_p1   <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (!stall) begin
            vld_p1 <= bus.in_valid;
            op_p1  <= bus.opcode;
            a_p1   <= bus.A;
            b_p1   <= bus.B;
        end
    end

    // Stage 2: result and flag register; bubbles leave the flags untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2   <= 1'b0;
            res_p2   <= '0;
            flags_p2 <= '0;
        end else if (flush) begin
            vld_p2 <= 1'b0;
        end else if (!stall) begin
            vld_p2 <= vld_p1;
            res_p2 <= res_c;
            if (vld_p1)
                flags_p2 <= flags_c;
        end
    end

    assign bus.out_valid = vld_p2;
    assign bus.Result    = res_p2;
    assign bus.Flags     = flags_p2;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed bench for alu_ex_stage: vector table plus stall, flush and async-reset sequences.
module tb_alu_ex_stage;

    logic clk;
    logic rst_n;
    logic stall;
    logic flush;

    alu_ex_if #(.WIDTH(16)) bus ();

    alu_ex_stage #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (stall),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [2:0]  flg;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp;
    int   n_fail;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_ov(input string name, input logic exp);
        chk({name, ".out_valid"}, {15'd0, bus.out_valid}, {15'd0, exp});
    endtask

    task automatic chk_out(input string name, input logic [15:0] res, input logic [2:0] flg);
        chk_ov(name, 1'b1);
        chk({name, ".Result"}, bus.Result, res);
        chk({name, ".Flags"}, {13'd0, bus.Flags}, {13'd0, flg});
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.in_valid = v;
        bus.opcode   = op;
        bus.A        = a;
        bus.B        = b;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        stall  = 1'b0;
        flush  = 1'b0;
        drive(1'b0, 4'h0, 16'h0000, 16'h0000);

        vecs.push_back('{4'b0000, 16'h7FF0, 16'h0020, 16'h7FFF, 3'b010});
        vecs.push_back('{4'b0001, 16'h8000, 16'h0001, 16'h8000, 3'b011});
        vecs.push_back('{4'b0001, 16'h0005, 16'h0005, 16'h0000, 3'b100});
        vecs.push_back('{4'b0111, 16'h7183, 16'h1881, 16'h7984, 3'b100});
        vecs.push_back('{4'b0001, 16'h8000, 16'h0001, 16'h8000, 3'b011});
        vecs.push_back('{4'b0010, 16'h00FF, 16'h00FF, 16'h0000, 3'b111});
        vecs.push_back('{4'b0010, 16'h1234, 16'h0F0F, 16'h1D3B, 3'b011});
        vecs.push_back('{4'b0000, 16'hFFFF, 16'h0001, 16'h0000, 3'b100});
        vecs.push_back('{4'b0000, 16'h8000, 16'hFFFF, 16'h8000, 3'b011});
        vecs.push_back('{4'b0001, 16'h0000, 16'h8000, 16'h7FFF, 3'b010});
        vecs.push_back('{4'b0011, 16'h1111, 16'h2222, 16'h0000, 3'b010});
        vecs.push_back('{4'b0111, 16'h8888, 16'h8888, 16'h8888, 3'b010});
        vecs.push_back('{4'b0111, 16'h7777, 16'h7777, 16'h7777, 3'b010});
        vecs.push_back('{4'b0111, 16'hF1E2, 16'h1F2E, 16'h0000, 3'b010});
        vecs.push_back('{4'b0111, 16'h1234, 16'h4321, 16'h5555, 3'b010});
        vecs.push_back('{4'b0001, 16'hFFFF, 16'h8000, 16'h7FFF, 3'b000});
        vecs.push_back('{4'b0000, 16'h1234, 16'h4321, 16'h5555, 3'b000});
        vecs.push_back('{4'b1111, 16'h0001, 16'h0001, 16'h0000, 3'b000});

        // Reset values appear without any clock edge
        #1;
        chk_ov("reset", 1'b0);
        chk("reset.Result", bus.Result, 16'h0000);
        chk("reset.Flags", {13'd0, bus.Flags}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-issue vectors: idle, one edge in flight, then the result
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            chk_ov($sformatf("vec%0d.idle", i), 1'b0);
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            @(negedge clk);
            bus.in_valid = 1'b0;
            chk_ov($sformatf("vec%0d.lat1", i), 1'b0);
            @(negedge clk);
            chk_out($sformatf("vec%0d", i), vecs[i].res, vecs[i].flg);
        end

        // ADD, SUB, XOR back-to-back with a two-cycle stall after the second issue
        @(negedge clk);
        drive(1'b1, 4'b0000, 16'h0001, 16'h0002);
        @(negedge clk);
        drive(1'b1, 4'b0001, 16'h0001, 16'h0003);
        @(negedge clk);
        chk_out("stall.add", 16'h0003, 3'b000);
        drive(1'b1, 4'b0010, 16'h00F0, 16'h000F);
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk_out($sformatf("stall.hold%0d", k), 16'h0003, 3'b000);
        end
        stall = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk_out("stall.sub", 16'hFFFE, 3'b001);
        @(negedge clk);
        chk_out("stall.xor", 16'h00FF, 3'b001);
        @(negedge clk);
        chk_ov("stall.after", 1'b0);

        // Flush with an op in S1 and another at the input, stall also high
        @(negedge clk);
        drive(1'b1, 4'b0000, 16'h7FF0, 16'h0020);
        @(negedge clk);
        drive(1'b1, 4'b0010, 16'h1234, 16'h1234);
        flush = 1'b1;
        stall = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        stall = 1'b0;
        bus.in_valid = 1'b0;
        chk_ov("flush.e0", 1'b0);
        chk("flush.e0.Result", bus.Result, 16'h00FF);
        chk("flush.e0.Flags", {13'd0, bus.Flags}, 16'h0001);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            chk_ov($sformatf("flush.e%0d", k), 1'b0);
            chk($sformatf("flush.e%0d.Flags", k), {13'd0, bus.Flags}, 16'h0001);
        end

        // Asynchronous reset between edges with ops in both stages
        @(negedge clk);
        drive(1'b1, 4'b0000, 16'hFFFF, 16'hFFFF);
        @(negedge clk);
        drive(1'b1, 4'b0001, 16'h0009, 16'h0002);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk_out("arst.pre", 16'hFFFE, 3'b001);
        #2;
        rst_n = 1'b0;
        #1;
        chk_ov("arst.now", 1'b0);
        chk("arst.now.Result", bus.Result, 16'h0000);
        chk("arst.now.Flags", {13'd0, bus.Flags}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        chk_ov("arst.held", 1'b0);
        @(negedge clk);
        chk_ov("arst.rel1", 1'b0);
        drive(1'b1, 4'b0000, 16'h0002, 16'h0003);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk_ov("arst.lat1", 1'b0);
        @(negedge clk);
        chk_out("arst.first", 16'h0005, 3'b000);
        @(negedge clk);
        chk_ov("arst.after", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
